// File: rtl/irq_pkg.sv
// Shared constants for the interrupt priority controller: FSM state codes and
// default vector placement.
package irq_pkg;

    localparam logic [0:0]  ST_IDLE        = 1'b0;
    localparam logic [0:0]  ST_REQ         = 1'b1;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: highest set request whose level (index+1) exceeds lvl.
// With lvl = 0 it is a plain highest-set-bit search.
module irq_prio_enc #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_vec,
    input  logic [ID_W:0]   lvl,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    localparam int LW = ID_W + 1;

    // Scan upward so the highest eligible index is the last one kept
    always_comb begin
        idx   = {ID_W{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_vec[i] && (LW'(i + 1) > lvl)) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt controller: edge-detects IRQ lines, arbitrates by fixed priority with
// nesting, and hands one request at a time to the pipeline via req/ack.
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int               NUM_IRQ    = 3,
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(VEC_BASE_DEF),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(VEC_STRIDE_DEF),
    parameter int               ID_W       = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               ie,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [WIDTH-1:0]   int_vec,
    output logic [NUM_IRQ-1:0] IRW,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int LW = ID_W + 1;

    logic [NUM_IRQ-1:0] irq_prev_r, pending_r, irw_r;
    logic [0:0]         state_r, state_nxt_s;
    logic               int_req_r, req_nxt_s;
    logic [ID_W-1:0]    int_id_r, id_nxt_s;
    logic [WIDTH-1:0]   int_vec_r, vec_nxt_s;

    logic [NUM_IRQ-1:0] rise_s, ret_oh_s, ack_oh_s, irw_nxt_s, pend_nxt_s;
    logic [ID_W-1:0]    top_idx_s, cand_idx_s;
    logic               irw_any_s, cand_any_s, cand_valid_s, ack_s, ret_s;
    logic [ID_W:0]      cur_lvl_s;

    irq_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_svc_enc (
        .req_vec (irw_r),
        .lvl     ({LW{1'b0}}),
        .idx     (top_idx_s),
        .valid   (irw_any_s)
    );

    irq_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_cand_enc (
        .req_vec (pending_r & irq_mask),
        .lvl     (cur_lvl_s),
        .idx     (cand_idx_s),
        .valid   (cand_any_s)
    );

    assign rise_s       = IRQ & ~irq_prev_r;
    assign cur_lvl_s    = irw_any_s ? ({1'b0, top_idx_s} + LW'(1)) : {LW{1'b0}};
    assign cand_valid_s = cand_any_s & ie;
    assign ack_s        = int_ack & (state_r == ST_REQ);
    assign ret_s        = int_ret & irw_any_s;

    // Return clears the top in-service bit before the ack sets its own bit; a
    // rise of the acked line re-arms its pending bit.
    assign ret_oh_s   = NUM_IRQ'(ret_s) << top_idx_s;
    assign ack_oh_s   = NUM_IRQ'(ack_s) << int_id_r;
    assign irw_nxt_s  = (irw_r & ~ret_oh_s) | ack_oh_s;
    assign pend_nxt_s = (pending_r & ~ack_oh_s) | rise_s;

    // Request FSM next-state: issue in IDLE, freeze or drop in REQ
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = int_req_r;
        id_nxt_s    = int_id_r;
        vec_nxt_s   = int_vec_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_valid_s) begin
                    state_nxt_s = ST_REQ;
                    req_nxt_s   = 1'b1;
                    id_nxt_s    = cand_idx_s;
                    vec_nxt_s   = VEC_BASE + (WIDTH'(cand_idx_s) * VEC_STRIDE);
                end else begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                end else if (!ie || !irq_mask[int_id_r]) begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_REQ;
                    req_nxt_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State registers; irq_prev tracks IRQ even in reset so a line held
    // across reset does not fire again until it falls and rises.
    always_ff @(posedge clk) begin
        irq_prev_r <= IRQ;
        if (rst) begin
            pending_r <= {NUM_IRQ{1'b0}};
            irw_r     <= {NUM_IRQ{1'b0}};
            state_r   <= ST_IDLE;
            int_req_r <= 1'b0;
            int_id_r  <= {ID_W{1'b0}};
            int_vec_r <= VEC_BASE;
        end else begin
            pending_r <= pend_nxt_s;
            irw_r     <= irw_nxt_s;
            state_r   <= state_nxt_s;
            int_req_r <= req_nxt_s;
            int_id_r  <= id_nxt_s;
            int_vec_r <= vec_nxt_s;
        end
    end

    assign int_req = int_req_r;
    assign int_id  = int_id_r;
    assign int_vec = int_vec_r;
    assign IRW     = irw_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed plus randomized bench for irq_priority_ctrl against a rule-level
// model of pending, in-service and request behaviour.
module tb_irq_priority_ctrl;

    logic        clk = 1'b0;
    logic        rst, ie, int_ack, int_ret;
    logic [2:0]  IRQ, irq_mask;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  IRW, pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2:0]  m_prev, m_pend, m_irw;
    logic        m_req;
    logic [1:0]  m_id;
    logic [31:0] m_vec;

    irq_priority_ctrl dut (
        .clk(clk), .rst(rst), .IRQ(IRQ), .ie(ie), .irq_mask(irq_mask),
        .int_ack(int_ack), .int_ret(int_ret), .int_req(int_req),
        .int_id(int_id), .int_vec(int_vec), .IRW(IRW), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the rules: level = top in-service index + 1, candidate is
    // the highest pending & enabled line above that level.
    task automatic model_step();
        int         lvl, best;
        logic [2:0] n_irw, n_pend;
        logic       ack;
        if (rst) begin
            m_prev = IRQ; m_pend = 3'b000; m_irw = 3'b000;
            m_req = 1'b0; m_id = 2'd0; m_vec = 32'h0000_0100;
        end else begin
            lvl = 0;
            for (int i = 0; i < 3; i++) if (m_irw[i]) lvl = i + 1;
            best = -1;
            for (int i = 0; i < 3; i++) if (m_pend[i] && irq_mask[i] && (i + 1 > lvl)) best = i;
            ack = m_req && int_ack;
            n_irw = m_irw;
            if (int_ret && lvl > 0) n_irw[lvl-1] = 1'b0;
            if (ack) n_irw[m_id] = 1'b1;
            n_pend = m_pend;
            if (ack) n_pend[m_id] = 1'b0;
            for (int i = 0; i < 3; i++) if (IRQ[i] && !m_prev[i]) n_pend[i] = 1'b1;
            if (!m_req) begin
                if (ie && best >= 0) begin
                    m_req = 1'b1;
                    m_id  = 2'(best);
                    m_vec = 32'h0000_0100 + 32'(best) * 32'h0000_0010;
                end
            end else if (ack) begin
                m_req = 1'b0;
            end else if (!ie || !irq_mask[m_id]) begin
                m_req = 1'b0;
            end
            m_irw = n_irw; m_pend = n_pend; m_prev = IRQ;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("int_req", 32'(int_req), 32'(m_req));
        chk("int_id",  32'(int_id),  32'(m_id));
        chk("int_vec", int_vec,      m_vec);
        chk("IRW",     32'(IRW),     32'(m_irw));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic pulse(input logic [2:0] lines);
        IRQ = lines; cycle(); IRQ = 3'b000;
    endtask

    task automatic ack();
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
    endtask

    task automatic ret();
        int_ret = 1'b1; cycle(); int_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ie = 1'b1; irq_mask = 3'b111; IRQ = 3'b000;
        int_ack = 1'b0; int_ret = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_req", 32'(int_req), 32'h0);
        chk("rst_vec", int_vec, 32'h0000_0100);
        chk("rst_irw", 32'(IRW), 32'h0);

        // Basic request for line 0
        pulse(3'b001);
        chk("p0_pend", 32'(pending), 32'h1);
        chk("p0_noreq", 32'(int_req), 32'h0);
        cycle();
        chk("p0_req", 32'(int_req), 32'h1);
        chk("p0_id", 32'(int_id), 32'h0);
        chk("p0_vec", int_vec, 32'h0000_0100);
        ack();
        chk("p0_irw", 32'(IRW), 32'h1);
        chk("p0_reqlo", 32'(int_req), 32'h0);

        // Nesting line 2 over line 0
        pulse(3'b100); cycle();
        chk("n2_id", 32'(int_id), 32'h2);
        chk("n2_vec", int_vec, 32'h0000_0120);
        ack();
        chk("n2_irw", 32'(IRW), 32'h5);
        ret();
        chk("n2_ret1", 32'(IRW), 32'h1);
        ret();
        chk("n2_ret2", 32'(IRW), 32'h0);

        // Blocking: line 1 waits behind in-service line 2
        pulse(3'b100); cycle(); ack();
        chk("blk_irw", 32'(IRW), 32'h4);
        pulse(3'b010); cycle(); cycle();
        chk("blk_pend", 32'(pending), 32'h2);
        chk("blk_noreq", 32'(int_req), 32'h0);
        ret(); cycle();
        chk("blk_req", 32'(int_req), 32'h1);
        chk("blk_id", 32'(int_id), 32'h1);
        ack(); ret();

        // Simultaneous rise: line 1 first, then line 0
        pulse(3'b011); cycle();
        chk("sim_id1", 32'(int_id), 32'h1);
        ack(); cycle();
        chk("sim_hold", 32'(int_req), 32'h0);
        ret(); cycle();
        chk("sim_id0", 32'(int_id), 32'h0);
        chk("sim_req0", 32'(int_req), 32'h1);
        ack(); ret();

        // Global enable gating
        ie = 1'b0;
        pulse(3'b001); cycle(); cycle();
        chk("ie_pend", 32'(pending), 32'h1);
        chk("ie_noreq", 32'(int_req), 32'h0);
        ie = 1'b1; cycle();
        chk("ie_req", 32'(int_req), 32'h1);
        // Withdraw on mask drop keeps pending
        irq_mask = 3'b110; cycle();
        chk("wd_req", 32'(int_req), 32'h0);
        chk("wd_pend", 32'(pending), 32'h1);
        irq_mask = 3'b111; cycle(); ack(); ret();

        // Return and ack in one cycle
        pulse(3'b001); cycle(); ack();
        pulse(3'b100); cycle();
        int_ret = 1'b1; int_ack = 1'b1; cycle(); int_ret = 1'b0; int_ack = 1'b0;
        chk("retack_irw", 32'(IRW), 32'h4);
        ret();

        // Reset mid-request with IRW = 011, lines held high
        pulse(3'b001); cycle(); ack();
        IRQ = 3'b010; cycle(); cycle(); ack();
        chk("rr_irw", 32'(IRW), 32'h3);
        IRQ = 3'b110; cycle(); cycle();
        chk("rr_req", 32'(int_req), 32'h1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rr_rreq", 32'(int_req), 32'h0);
        chk("rr_rirw", 32'(IRW), 32'h0);
        chk("rr_rpend", 32'(pending), 32'h0);
        chk("rr_rvec", int_vec, 32'h0000_0100);
        cycle(); cycle();
        chk("rr_hold", 32'(pending), 32'h0);
        IRQ = 3'b000; cycle();
        IRQ = 3'b100; cycle();
        chk("rr_rearm", 32'(pending), 32'h4);
        IRQ = 3'b000; cycle(); ack(); ret();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            IRQ      = IRQ ^ (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
            ie       = ($urandom_range(0, 19) != 0);
            irq_mask = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            int_ack  = ($urandom_range(0, 1) == 1);
            int_ret  = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
